// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between an ALU (A) and a long-latency unit (B),
// tracks outstanding long-latency destinations and stalls decode; WB_BYPASS_EN adds a write-port bypass.
module regfile_wb_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              issue_long_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              stall_o,
`ifdef WB_BYPASS_EN
  output logic              byp1_hit_o,
  output logic              byp2_hit_o,
  output logic [DATA_W-1:0] byp_data_o,
`endif
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);
  localparam int NREG = 1 << ADDR_W;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [3:0]        wait_q, wait_d;
  logic              b_turn, grant_a, grant_b, busy1, busy2, wr_en_d;
  logic [ADDR_W-1:0] win_addr, wr_addr_d;
  logic [DATA_W-1:0] win_data, wr_data_d;
  assign b_turn    = wait_q >= 4'(MAX_WAIT);
  assign grant_a   = !reset_i && a_valid_i && !(b_valid_i && b_turn);
  assign grant_b   = !reset_i && b_valid_i && !(a_valid_i && !b_turn);
  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;
  assign win_addr  = grant_a ? a_addr_i : b_addr_i;
  assign win_data  = grant_a ? a_data_i : b_data_i;
`ifdef WB_BYPASS_EN
  assign byp1_hit_o = wr_en_o && wr_addr_o == rs1_addr_i && rs1_addr_i != '0;
  assign byp2_hit_o = wr_en_o && wr_addr_o == rs2_addr_i && rs2_addr_i != '0;
  assign byp_data_o = wr_data_o;
  assign busy1      = busy_q[rs1_addr_i] && !byp1_hit_o;
  assign busy2      = busy_q[rs2_addr_i] && !byp2_hit_o;
`else
  assign busy1      = busy_q[rs1_addr_i];
  assign busy2      = busy_q[rs2_addr_i];
`endif
  assign stall_o = busy1 || busy2 || (issue_long_i && busy_q[issue_rd_i]);
  always_comb begin
    wait_d    = (b_valid_i && !grant_b) ? (wait_q == 4'hf ? wait_q : wait_q + 4'd1) : 4'd0;
    wr_en_d   = (grant_a || grant_b) && win_addr != '0;
    wr_addr_d = wr_en_d ? win_addr : wr_addr_o;
    wr_data_d = wr_en_d ? win_data : wr_data_o;
    busy_d    = busy_q;
    if (grant_b) busy_d[b_addr_i] = 1'b0;
    // a fresh issue to the same register outranks the completing one
    if (issue_long_i && !stall_o && issue_rd_i != '0) busy_d[issue_rd_i] = 1'b1;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q    <= '0;
      wait_q    <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      busy_q    <= busy_d;
      wait_q    <= wait_d;
      wr_en_o   <= wr_en_d;
      wr_addr_o <= wr_addr_d;
      wr_data_o <= wr_data_d;
    end
  end
endmodule
